// File: rtl/ad9228_tx_gearbox.sv
// rtl/ad9228_tx_gearbox.sv - packs 12-bit sample pairs into 8-bit data/fco slices for an 8:1 serializer pair
// Optional ramp test pattern source: define AD9228_TX_TESTPAT_EN (adds the test_mode input).
module ad9228_tx_gearbox #(
  parameter int          DATA_WIDTH = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] IDLE_WORD  = 12'h800
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_en,
`ifdef AD9228_TX_TESTPAT_EN
  input  logic                  test_mode,
`endif
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            data_out,
  output logic [7:0]            fco_out,
  output logic                  frame_start,
  output logic [15:0]           underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DATA_WIDTH != 12) begin : g_bad_width
      $error("ad9228_tx_gearbox: DATA_WIDTH must be 12");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ad9228_tx_gearbox: FIFO_DEPTH must be a power of 2, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;

  phase_t        phase;
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    hold;
  logic [11:0]   ramp;
  logic          use_ramp;
  logic          fifo_empty, pop_phase, push, pop, underrun;
  logic [11:0]   next_word;

`ifdef AD9228_TX_TESTPAT_EN
  assign use_ramp = test_mode;
`else
  assign use_ramp = 1'b0;
  assign ramp     = 12'h000;
`endif

  assign word_ready = (count < CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop_phase  = tx_en && (phase != PH2);
  assign push       = word_valid && word_ready;
  assign pop        = pop_phase && !use_ramp && !fifo_empty;
  assign underrun   = pop_phase && !use_ramp && fifo_empty;
  // Pops read the pre-edge FIFO contents, so a word pushed this cycle is never bypassed.
  assign next_word  = use_ramp ? ramp : (fifo_empty ? IDLE_WORD : mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

`ifdef AD9228_TX_TESTPAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       ramp <= 12'h000;
    else if (pop_phase && use_ramp)  ramp <= ramp + 12'h001;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase        <= PH0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold         <= 8'h00;
      data_out     <= 8'h00;
      fco_out      <= 8'h00;
      frame_start  <= 1'b0;
      underrun_cnt <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'h0001;

      if (!tx_en) begin
        // A pair interrupted mid-way is dropped; the next enabled edge restarts at phase 0.
        phase       <= PH0;
        hold        <= 8'h00;
        data_out    <= 8'h00;
        fco_out     <= 8'h00;
        frame_start <= 1'b0;
      end else begin
        case (phase)
          PH0: begin
            data_out    <= next_word[11:4];
            fco_out     <= 8'hFC;
            hold        <= next_word[7:0];
            frame_start <= 1'b1;
            phase       <= PH1;
          end
          PH1: begin
            data_out    <= {hold[3:0], next_word[11:8]};
            fco_out     <= 8'h0F;
            hold        <= next_word[7:0];
            frame_start <= 1'b0;
            phase       <= PH2;
          end
          default: begin
            data_out    <= hold;
            fco_out     <= 8'hC0;
            frame_start <= 1'b0;
            phase       <= PH0;
          end
        endcase
      end
    end
  end

endmodule
